piso_tx: RTL

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first on a single registered serial line, framed by a `frame` strobe, with an optional even-parity bit. It is the transmit end of the single-bit serial link whose receive end is a flip-flop-based sampler. The block drives serial stimulus into that sampler chain and provides the serial source for the link in the datapath.

---
 rtl/piso_tx.sv | 117 +++++++++++
 1 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter.
// A WIDTH-bit word is accepted through a valid/ready handshake. It is shifted
// out MSB-first on a registered serial line, framed by a registered strobe.
// An even-parity bit can optionally follow the data bits. A registered done
// pulse follows each completed frame.
module piso_tx #(
  parameter int WIDTH  = 8,
  parameter int PARITY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             sdo,
  output logic             frame,
  output logic             done
);

  // Total serial positions in one frame (data bits plus optional parity bit).
  localparam int FRAME_LEN = WIDTH + ((PARITY != 0) ? 1 : 0);
  // The counter holds FRAME_LEN-1 at most.
  localparam int CW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             par_q,   par_d;
  logic             sdo_q,   sdo_d;
  logic             frame_q, frame_d;
  logic             done_q,  done_d;

  // Ready only when idle. Ready is also forced low while reset is held.
  assign load_ready = (state_q == IDLE) && !rst;

  // Next-state logic: accept in IDLE, shift or emit parity in SHIFT, close the frame.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    // Outside a frame the line idles low and done is a single-cycle pulse.
    // These three therefore default to 0 on every edge.
    sdo_d   = 1'b0;
    frame_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          // The first bit goes out immediately. The rest wait in shreg, MSB-aligned.
          shreg_d = data_in << 1;
          sdo_d   = data_in[WIDTH-1];
          frame_d = 1'b1;
          par_d   = ^data_in;
          cnt_d   = CW'(FRAME_LEN - 1);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CW'(1);
          frame_d = 1'b1;
          if ((PARITY != 0) && (cnt_q == CW'(1))) begin
            // The last position of a parity frame carries the even-parity bit.
            sdo_d = par_q;
          end else begin
            sdo_d   = shreg_q[WIDTH-1];
            shreg_d = shreg_q << 1;
          end
        end else begin
          // All positions sent. Drop the frame and pulse done. Ready returns this cycle.
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous and abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      sdo_q   <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop see pre-edge values,
      // regardless of statement order.
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      sdo_q   <= sdo_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  assign sdo   = sdo_q;
  assign frame = frame_q;
  assign done  = done_q;

endmodule
